test_din: RTL and testbench
===========================

TEST_DIN -- requirements
Module: test_din

Interface
REQ-001 Parameter DWIDTH, default 16: width of the data word.
REQ-002 Parameter DEPTH, default 8: number of buffer entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 din_valid  input  1  upstream word present this cycle; there is no backpressure to upstream.
REQ-006 din_data  input  DWIDTH  upstream word, sampled when din_valid=1.
REQ-007 dout_valid  output  1  buffered word available on dout_data.
REQ-008 dout_ready  input  1  downstream accepts the word; a pop occurs when dout_valid and dout_ready are both 1.
REQ-009 dout_data  output  DWIDTH  oldest buffered word.
REQ-010 level  output  $clog2(DEPTH)+1  current number of buffered words.
REQ-011 overflow  output  1  sticky flag: a valid input word was dropped.
REQ-012 ovf_clr  input  1  synchronous clear of overflow.
REQ-013 checksum  output  DWIDTH  sum of all accepted words, modulo 2^DWIDTH.
REQ-014 word_cnt  output  32  count of accepted words; wraps from 2^32-1 to 0.

Function
REQ-015 The block SHALL be a circular FIFO with a write pointer and a read pointer, each log2(DEPTH) bits wide, plus a level counter.
REQ-016 A write SHALL be accepted when din_valid=1 and either level<DEPTH or a pop occurs in the same cycle.
REQ-017 A write SHALL store din_data at the write pointer and then advance the pointer modulo DEPTH.
REQ-018 A pop SHALL advance the read pointer modulo DEPTH.
REQ-019 level SHALL update as follows:
- +1 on a write only
- -1 on a pop only
- unchanged when a write and a pop occur in the same cycle
REQ-020 dout_valid SHALL equal (level!=0), and dout_data SHALL be the entry at the read pointer (first-word-fall-through).
REQ-021 A word written at edge N SHALL appear with dout_valid=1 after edge N when the buffer was empty; latency is 1 cycle.
REQ-022 dout_data SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-023 When level=DEPTH, din_valid=1 and no pop occurs, the word SHALL be dropped, overflow SHALL go to 1 at that edge, and the FIFO contents, pointers and level SHALL be unchanged.
REQ-024 When ovf_clr=1, overflow SHALL go to 0 at the next edge.
REQ-025 If ovf_clr=1 and a drop occur in the same cycle, overflow SHALL be 1 (set wins).
REQ-026 When level=0, dout_ready SHALL have no effect; level SHALL not go below 0.
REQ-027 On each accepted write, checksum SHALL become (checksum + din_data) mod 2^DWIDTH and word_cnt SHALL increment by 1.
REQ-028 Dropped words SHALL NOT affect checksum or word_cnt.
REQ-029 With DEPTH=8, the pointers SHALL wrap from 7 to 0 with no gap in ordering.
REQ-030 Words SHALL leave the FIFO in exactly the order they were accepted.

Reset
REQ-031 While rst=1, the following SHALL be held at 0 immediately, without waiting for a clock edge:
- write pointer and read pointer
- level
- dout_valid
- overflow
- checksum
- word_cnt
REQ-032 dout_data SHALL be don't-care during reset; storage contents need not be cleared.
REQ-033 Assertion of rst mid-stream SHALL discard all buffered words.
REQ-034 Inputs present while rst=1 SHALL be ignored.
REQ-035 The first edge after rst deasserts SHALL accept input normally.

Verification
REQ-036 Single word:
- Stimulus: after reset, one cycle with din_valid=1, din_data=0x1234, dout_ready=0.
- Response: dout_valid=1, dout_data=0x1234, level=1, word_cnt=1, checksum=0x1234.
REQ-037 Fill and overflow:
- Stimulus: 9 consecutive writes 1..9 with dout_ready=0.
- Response: level=8, overflow=1, checksum=36, word_cnt=8; draining then yields 1..8.
REQ-038 Simultaneous write and pop at full:
- Stimulus: level=8, dout_ready=1, din_valid=1, din_data=0xAA.
- Response: level stays 8, overflow stays 0, 0xAA is the last word out.
REQ-039 Wrap-around:
- Stimulus: 20 writes 0..19 with dout_ready=1 every cycle.
- Response: outputs 0..19 in order, each 1 cycle after its write, and level never exceeds 1.
REQ-040 Overflow set/clear precedence:
- Stimulus: overflow=1 with ovf_clr=1 for one cycle; then, at full, a drop and ovf_clr=1 in the same cycle.
- Response: overflow=0 after the first cycle, and overflow=1 after the second.
REQ-041 Mid-stream reset:
- Stimulus: level=5, then assert rst between clock edges.
- Response: level=0, dout_valid=0, checksum=0 and word_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/test_din.sv
// test_din -- first-word-fall-through circular FIFO with input statistics.
//
// Purpose:
//   Buffers an upstream word stream that has no backpressure. Words are
//   stored in a DEPTH-entry circular buffer and presented to the downstream
//   side oldest-first. An input word that arrives while the buffer is full
//   and no pop is happening is dropped. A dropped word sets a sticky overflow
//   flag. The block also keeps a running modulo-2^DWIDTH sum and a 32-bit
//   count of every accepted word.
//
// Ports:
//   clk         in   1        single clock, rising edge
//   rst         in   1        asynchronous, active-high reset
//   din_valid   in   1        upstream word present this cycle
//   din_data    in   DWIDTH   upstream word
//   dout_valid  out  1        a buffered word is on dout_data
//   dout_ready  in   1        downstream accepts dout_data (pop when valid)
//   dout_data   out  DWIDTH   oldest buffered word
//   level       out  AW+1     number of buffered words
//   overflow    out  1        sticky: a valid input word was dropped
//   ovf_clr     in   1        synchronous clear of overflow
//   checksum    out  DWIDTH   sum of accepted words, modulo 2^DWIDTH
//   word_cnt    out  32       count of accepted words, wrapping
module test_din #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din_valid,
  input  logic [DWIDTH-1:0]          din_data,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [DWIDTH-1:0]          dout_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       ovf_clr,
  output logic [DWIDTH-1:0]          checksum,
  output logic [31:0]                word_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [LW-1:0]     r_level;
  logic              r_ovf;
  logic [DWIDTH-1:0] r_sum;
  logic [31:0]       r_cnt;

  logic w_pop;
  logic w_full;
  logic w_wr;
  logic w_drop;

  // A pop frees a slot in the same cycle, so a full buffer can still accept
  // a write when the downstream side is draining it.
  assign w_pop  = (r_level != '0) && dout_ready;
  assign w_full = (r_level == LW'(DEPTH));
  assign w_wr   = din_valid && (!w_full || w_pop);
  assign w_drop = din_valid && w_full && !w_pop;

  // Storage is not reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr && !rst) begin
      r_mem[r_wptr] <= din_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_sum   <= '0;
      r_cnt   <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
        r_sum  <= r_sum + din_data;
        r_cnt  <= r_cnt + 32'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      // A drop in the same cycle as a clear leaves the flag set.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign dout_valid = (r_level != '0);
  assign dout_data  = r_mem[r_rptr];
  assign level      = r_level;
  assign overflow   = r_ovf;
  assign checksum   = r_sum;
  assign word_cnt   = r_cnt;

endmodule

// File: tb/tb_test_din.sv
// Directed testbench for test_din (DWIDTH=16, DEPTH=8).
module tb_test_din;

  localparam int DWIDTH = 16;
  localparam int DEPTH  = 8;

  logic              clk;
  logic              rst;
  logic              din_valid;
  logic [DWIDTH-1:0] din_data;
  logic              dout_valid;
  logic              dout_ready;
  logic [DWIDTH-1:0] dout_data;
  logic [3:0]        level;
  logic              overflow;
  logic              ovf_clr;
  logic [DWIDTH-1:0] checksum;
  logic [31:0]       word_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  test_din #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din_data   (din_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .level      (level),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .checksum   (checksum),
    .word_cnt   (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between clock edges, release it just after an edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    din_valid  = 1'b0;
    din_data   = '0;
    dout_ready = 1'b0;
    ovf_clr    = 1'b0;

    // Reset asserted before any clock edge: outputs must clear asynchronously.
    #2 rst = 1'b1;
    #1;
    check("rst_level",    level,      0);
    check("rst_valid",    dout_valid, 0);
    check("rst_ovf",      overflow,   0);
    check("rst_checksum", checksum,   0);
    check("rst_word_cnt", word_cnt,   0);
    tick();
    tick();
    rst = 1'b0;

    // Single word.
    din_valid = 1'b1; din_data = 16'h1234;
    tick();
    din_valid = 1'b0;
    check("single_valid", dout_valid, 1);
    check("single_data",  dout_data,  16'h1234);
    check("single_level", level,      1);
    check("single_cnt",   word_cnt,   1);
    check("single_sum",   checksum,   16'h1234);
    dout_ready = 1'b1;
    tick();
    check("single_pop_level", level, 0);
    check("single_pop_valid", dout_valid, 0);
    // Pop request on an empty buffer has no effect.
    tick();
    check("empty_pop_level", level, 0);
    dout_ready = 1'b0;

    // Fill and overflow: 9 writes 1..9.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      din_valid = 1'b1; din_data = DWIDTH'(i);
      tick();
    end
    din_valid = 1'b0;
    check("fill_level", level,    8);
    check("fill_ovf",   overflow, 1);
    check("fill_sum",   checksum, 36);
    check("fill_cnt",   word_cnt, 8);
    tick();
    check("hold_data", dout_data, 1);
    dout_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_%0d", i), dout_data, i);
      tick();
    end
    dout_ready = 1'b0;
    check("drain_level", level, 0);
    check("drain_valid", dout_valid, 0);

    // Overflow clear, then drop + clear in the same cycle.
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    for (int i = 0; i < 8; i++) begin
      din_valid = 1'b1; din_data = DWIDTH'(16'h10 + i);
      tick();
    end
    check("refill_level", level, 8);
    check("refill_ovf",   overflow, 0);
    din_data = 16'h55; ovf_clr = 1'b1;
    tick();
    din_valid = 1'b0; ovf_clr = 1'b0;
    check("ovf_set_wins", overflow, 1);
    check("drop_level",   level, 8);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr2", overflow, 0);

    // Write and pop together at full.
    dout_ready = 1'b1; din_valid = 1'b1; din_data = 16'hAA;
    tick();
    din_valid = 1'b0; dout_ready = 1'b0;
    check("wp_full_level", level, 8);
    check("wp_full_ovf",   overflow, 0);
    dout_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check($sformatf("wp_drain_%0d", i), dout_data, 16'h10 + i);
      tick();
    end
    check("wp_last_aa", dout_data, 16'hAA);
    tick();
    dout_ready = 1'b0;
    check("wp_empty", level, 0);

    // Wrap-around with continuous draining.
    do_reset();
    dout_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din_valid = 1'b1; din_data = DWIDTH'(i);
      tick();
      check($sformatf("wrap_data_%0d", i), dout_data, i);
      check($sformatf("wrap_lvl_%0d", i), {dout_valid, level}, {1'b1, 4'd1});
    end
    din_valid = 1'b0;
    tick();
    dout_ready = 1'b0;
    check("wrap_end_level", level, 0);
    check("wrap_cnt", word_cnt, 20);
    check("wrap_sum", checksum, 190);

    // Mid-stream reset.
    for (int i = 0; i < 5; i++) begin
      din_valid = 1'b1; din_data = DWIDTH'(16'h100 + i);
      tick();
    end
    din_valid = 1'b0;
    check("mid_level5", level, 5);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_level", level,      0);
    check("mid_rst_valid", dout_valid, 0);
    check("mid_rst_sum",   checksum,   0);
    check("mid_rst_cnt",   word_cnt,   0);
    // Inputs present during reset are ignored.
    din_valid = 1'b1; din_data = 16'h77;
    tick();
    check("rst_ignore_level", level, 0);
    check("rst_ignore_cnt",   word_cnt, 0);
    rst = 1'b0;
    tick();
    din_valid = 1'b0;
    check("post_rst_level", level, 1);
    check("post_rst_data",  dout_data, 16'h77);
    check("post_rst_cnt",   word_cnt, 1);
    check("post_rst_sum",   checksum, 16'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
